// File: rtl/fetch_types.sv
// Shared fetch-side types: the packet handed to the instruction queue, fetch FSM states
// and the default reset fetch address.
package fetch_types;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h1eceb000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_packet_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus bundle: I-cache request/response, enqueue handshake toward the
// instruction queue, and the backend redirect.
interface fetch_stage_if;
    import fetch_types::*;

    logic                icache_req_valid;
    logic                icache_req_ready;
    logic [XLEN-1:0]     icache_req_addr;
    logic                icache_resp_valid;
    logic [XLEN-1:0]     icache_resp_data;
    logic                out_valid;
    logic                out_ready;
    fetch_packet_t       out_packet;
    logic                redirect_valid;
    logic [XLEN-1:0]     redirect_pc;

    modport master (
        output icache_req_valid, icache_req_addr, out_valid, out_packet,
        input  icache_req_ready, icache_resp_valid, icache_resp_data, out_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  icache_req_valid, icache_req_addr, out_valid, out_packet,
        output icache_req_ready, icache_resp_valid, icache_resp_data, out_ready,
               redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_stage.sv
// Fetch unit: owns the fetch PC, keeps one I-cache request in flight, buffers the returned
// word in a one-entry output register and drops stale responses after a redirect.
module fetch_stage
    import fetch_types::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            buf_valid_q, buf_valid_d;
    fetch_packet_t   buf_q, buf_d;
    logic            req_valid;
    logic            req_fire;
    logic            resp_load;

    // Next-state, request issue and buffer update; redirect overrides everything last.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        req_valid   = 1'b0;
        req_fire    = 1'b0;
        resp_load   = 1'b0;

        case (state_q)
            IDLE: begin
                // Only issue when the buffer will be free by the time the word returns.
                req_valid = ~rst && ~bus.redirect_valid && (~buf_valid_q || bus.out_ready);
                req_fire  = req_valid && bus.icache_req_ready;
                if (req_fire) begin
                    pc_d     = pc_q + XLEN'(4);
                    req_pc_d = pc_q;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (bus.icache_resp_valid) begin
                    resp_load  = 1'b1;
                    buf_d.pc   = req_pc_q;
                    buf_d.inst = bus.icache_resp_data;
                    state_d    = IDLE;
                end
            end
            DISCARD: begin
                if (bus.icache_resp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (resp_load) begin
            buf_valid_d = 1'b1;
        end else if (buf_valid_q && bus.out_ready) begin
            buf_valid_d = 1'b0;
        end

        if (bus.redirect_valid) begin
            pc_d        = bus.redirect_pc;
            buf_valid_d = 1'b0;
            if (state_q == WAIT && !bus.icache_resp_valid) begin
                state_d = DISCARD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    // Payload registers need no reset: they are only observed while their valid is set.
    always_ff @(posedge clk) begin
        req_pc_q <= req_pc_d;
        buf_q    <= buf_d;
    end

    assign bus.icache_req_valid = req_valid;
    assign bus.icache_req_addr  = pc_q;
    assign bus.out_valid        = buf_valid_q;
    assign bus.out_packet       = buf_q;

    a_req_only_idle: assert property (@(posedge clk) disable iff (rst)
        !(bus.icache_req_valid && state_q != IDLE));

    a_resp_only_outstanding: assert property (@(posedge clk) disable iff (rst)
        bus.icache_resp_valid |-> (state_q == WAIT || state_q == DISCARD));

    a_redirect_aligned: assert property (@(posedge clk) disable iff (rst)
        bus.redirect_valid |-> (bus.redirect_pc[1:0] == 2'b00));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, backpressure, cache stall, redirects, wrap
// and reset during an outstanding request, against a small latency-programmable I-cache.
module tb_fetch_stage;
    import fetch_types::*;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    fetch_stage_if bus();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // I-cache model: returns addr ^ A5A50000 'lat' cycles after the handshake; reset forgets it.
    int          lat    = 1;
    int          cnt    = 0;
    logic        pend   = 1'b0;
    logic [31:0] m_addr = '0;

    always @(posedge clk) begin
        if (rst || bus.icache_resp_valid) begin
            pend <= 1'b0;
        end else if (bus.icache_req_valid && bus.icache_req_ready) begin
            pend   <= 1'b1;
            cnt    <= lat;
            m_addr <= bus.icache_req_addr;
        end else if (pend && cnt > 1) begin
            cnt <= cnt - 1;
        end
    end

    always @(negedge clk) begin
        bus.icache_resp_valid = pend && (cnt == 1);
        bus.icache_resp_data  = m_addr ^ 32'ha5a50000;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid   = 1'b0;
        bus.redirect_pc      = '0;
        bus.out_ready        = 1'b1;
        bus.icache_req_ready = 1'b1;
        lat = 1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.redirect_valid   = 1'b0;
        bus.redirect_pc      = '0;
        bus.out_ready        = 1'b1;
        bus.icache_req_ready = 1'b1;
        lat = 1;
        tick();
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid); tests_failed++;
        end
        tests_run++;
        if (bus.icache_req_valid !== 1'b0) begin
            $display("FAIL reset_req_valid: got %b exp 0", bus.icache_req_valid); tests_failed++;
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 32'h1eceb000) begin
            $display("FAIL reset_first_req: got v=%b a=%h exp v=1 a=1eceb000",
                     bus.icache_req_valid, bus.icache_req_addr); tests_failed++;
        end
    endtask

    task automatic test_stream();
        logic [31:0]   exp_pc  [3] = '{32'h1eceb000, 32'h1eceb004, 32'h1eceb008};
        logic [31:0]   exp_ins [3] = '{32'hbb6bb000, 32'hbb6bb004, 32'hbb6bb008};
        logic [31:0]   exp_nxt [3] = '{32'h1eceb004, 32'h1eceb008, 32'h1eceb00c};
        fetch_packet_t exp;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (bus.out_valid !== 1'b0 || bus.icache_req_valid !== 1'b0) begin
                $display("FAIL stream_wait%0d: got ov=%b rv=%b exp ov=0 rv=0",
                         i, bus.out_valid, bus.icache_req_valid); tests_failed++;
            end
            tick();
            exp.pc   = exp_pc[i];
            exp.inst = exp_ins[i];
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_packet !== exp) begin
                $display("FAIL stream_pkt%0d: got ov=%b pkt=%h exp ov=1 pkt=%h",
                         i, bus.out_valid, bus.out_packet, exp); tests_failed++;
            end
            tests_run++;
            if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== exp_nxt[i]) begin
                $display("FAIL stream_reissue%0d: got v=%b a=%h exp v=1 a=%h",
                         i, bus.icache_req_valid, bus.icache_req_addr, exp_nxt[i]); tests_failed++;
            end
        end
    endtask

    task automatic test_backpressure();
        fetch_packet_t exp;
        do_reset();
        bus.out_ready = 1'b0;
        tick();
        exp.pc   = 32'h1eceb000;
        exp.inst = 32'hbb6bb000;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_packet !== exp || bus.icache_req_valid !== 1'b0) begin
                $display("FAIL bp_hold%0d: got ov=%b pkt=%h rv=%b exp ov=1 pkt=%h rv=0",
                         i, bus.out_valid, bus.out_packet, bus.icache_req_valid, exp); tests_failed++;
            end
        end
        bus.out_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 32'h1eceb004) begin
            $display("FAIL bp_release_req: got v=%b a=%h exp v=1 a=1eceb004",
                     bus.icache_req_valid, bus.icache_req_addr); tests_failed++;
        end
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL bp_pop: got ov=%b exp 0", bus.out_valid); tests_failed++;
        end
    endtask

    task automatic test_req_stall();
        fetch_packet_t exp;
        do_reset();
        bus.icache_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 32'h1eceb000 ||
                bus.out_valid !== 1'b0) begin
                $display("FAIL stall_hold%0d: got v=%b a=%h ov=%b exp v=1 a=1eceb000 ov=0",
                         i, bus.icache_req_valid, bus.icache_req_addr, bus.out_valid); tests_failed++;
            end
        end
        bus.icache_req_ready = 1'b1;
        tick();
        tick();
        exp.pc   = 32'h1eceb000;
        exp.inst = 32'hbb6bb000;
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_packet !== exp || bus.icache_req_addr !== 32'h1eceb004) begin
            $display("FAIL stall_done: got ov=%b pkt=%h a=%h exp ov=1 pkt=%h a=1eceb004",
                     bus.out_valid, bus.out_packet, bus.icache_req_addr, exp); tests_failed++;
        end
    endtask

    task automatic test_redirect_wait();
        fetch_packet_t exp;
        do_reset();
        lat = 2;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h00001000;
        #1;
        tests_run++;
        if (bus.icache_req_valid !== 1'b0) begin
            $display("FAIL rdw_req_forced: got %b exp 0", bus.icache_req_valid); tests_failed++;
        end
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        tests_run++;
        if (bus.icache_req_valid !== 1'b0) begin
            $display("FAIL rdw_discard_noreq: got %b exp 0", bus.icache_req_valid); tests_failed++;
        end
        lat = 1;
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.icache_req_valid !== 1'b1 ||
            bus.icache_req_addr !== 32'h00001000) begin
            $display("FAIL rdw_after_drop: got ov=%b v=%b a=%h exp ov=0 v=1 a=00001000",
                     bus.out_valid, bus.icache_req_valid, bus.icache_req_addr); tests_failed++;
        end
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL rdw_no_stale_pkt: got ov=%b exp 0", bus.out_valid); tests_failed++;
        end
        tick();
        exp.pc   = 32'h00001000;
        exp.inst = 32'ha5a51000;
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_packet !== exp) begin
            $display("FAIL rdw_pkt: got ov=%b pkt=%h exp ov=1 pkt=%h",
                     bus.out_valid, bus.out_packet, exp); tests_failed++;
        end
    endtask

    task automatic test_redirect_resp();
        fetch_packet_t exp;
        do_reset();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h00002000;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.icache_req_valid !== 1'b1 ||
            bus.icache_req_addr !== 32'h00002000) begin
            $display("FAIL rdr_same_cycle: got ov=%b v=%b a=%h exp ov=0 v=1 a=00002000",
                     bus.out_valid, bus.icache_req_valid, bus.icache_req_addr); tests_failed++;
        end
        tick();
        tick();
        exp.pc   = 32'h00002000;
        exp.inst = 32'ha5a52000;
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_packet !== exp) begin
            $display("FAIL rdr_pkt: got ov=%b pkt=%h exp ov=1 pkt=%h",
                     bus.out_valid, bus.out_packet, exp); tests_failed++;
        end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        bus.out_ready = 1'b0;
        tick();
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h00003000;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.icache_req_valid !== 1'b1 ||
            bus.icache_req_addr !== 32'h00003000) begin
            $display("FAIL rdf_flush: got ov=%b v=%b a=%h exp ov=0 v=1 a=00003000",
                     bus.out_valid, bus.icache_req_valid, bus.icache_req_addr); tests_failed++;
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_back_to_back_redirect();
        fetch_packet_t exp;
        do_reset();
        lat = 3;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h00004000;
        tick();
        bus.redirect_pc    = 32'h00005000;
        tick();
        bus.redirect_valid = 1'b0;
        lat = 1;
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.icache_req_valid !== 1'b1 ||
            bus.icache_req_addr !== 32'h00005000) begin
            $display("FAIL b2b_req: got ov=%b v=%b a=%h exp ov=0 v=1 a=00005000",
                     bus.out_valid, bus.icache_req_valid, bus.icache_req_addr); tests_failed++;
        end
        tick();
        tick();
        exp.pc   = 32'h00005000;
        exp.inst = 32'ha5a55000;
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_packet !== exp) begin
            $display("FAIL b2b_pkt: got ov=%b pkt=%h exp ov=1 pkt=%h",
                     bus.out_valid, bus.out_packet, exp); tests_failed++;
        end
    endtask

    task automatic test_pc_wrap();
        fetch_packet_t exp;
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hfffffffc;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        tests_run++;
        if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 32'hfffffffc) begin
            $display("FAIL wrap_req: got v=%b a=%h exp v=1 a=fffffffc",
                     bus.icache_req_valid, bus.icache_req_addr); tests_failed++;
        end
        tick();
        tick();
        exp.pc   = 32'hfffffffc;
        exp.inst = 32'h5a5afffc;
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_packet !== exp || bus.icache_req_addr !== 32'h00000000) begin
            $display("FAIL wrap_next: got ov=%b pkt=%h a=%h exp ov=1 pkt=%h a=00000000",
                     bus.out_valid, bus.out_packet, bus.icache_req_addr, exp); tests_failed++;
        end
    endtask

    task automatic test_reset_mid_wait();
        fetch_packet_t exp;
        do_reset();
        lat = 3;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h00006000;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        rst = 1'b1;
        lat = 1;
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.icache_req_valid !== 1'b0) begin
            $display("FAIL rstw_during: got ov=%b v=%b exp ov=0 v=0",
                     bus.out_valid, bus.icache_req_valid); tests_failed++;
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.icache_req_valid !== 1'b1 || bus.icache_req_addr !== 32'h1eceb000) begin
            $display("FAIL rstw_req: got v=%b a=%h exp v=1 a=1eceb000",
                     bus.icache_req_valid, bus.icache_req_addr); tests_failed++;
        end
        tick();
        tick();
        exp.pc   = 32'h1eceb000;
        exp.inst = 32'hbb6bb000;
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_packet !== exp) begin
            $display("FAIL rstw_pkt: got ov=%b pkt=%h exp ov=1 pkt=%h",
                     bus.out_valid, bus.out_packet, exp); tests_failed++;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_req_stall();
        test_redirect_wait();
        test_redirect_resp();
        test_redirect_flush();
        test_back_to_back_redirect();
        test_pc_wrap();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
